ultra_ranger: RTL and testbench
===============================

ULTRA_RANGER -- requirements
Module: ultra_ranger

Interface
REQ-001 Parameter NCH, default 4: number of sensor channels, 1..16, serviced round-robin.
REQ-002 Parameter W, default 16: width of pulse counter and measurement result, 8..32.
REQ-003 Parameter TRIG_CYC, default 11: trigger pulse length in clk cycles, >=1.
REQ-004 Parameter TIMEOUT_CYC, default 60000: maximum wait for echo rise and maximum echo high time, in cycles, < 2^W-1.
REQ-005 Parameter HOLDOFF_CYC, default 1000: idle gap after each measurement before the next trigger, >=1.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 enable  input  1  high: run ranging cycles; low: stop after current cycle.
REQ-009 echo  input  NCH  asynchronous echo pulses, bit i from sensor i.
REQ-010 trigger  output  NCH  registered trigger pulses, bit i to sensor i.
REQ-011 meas_valid  output  1  one-cycle strobe: meas_ch/meas_cnt/meas_timeout updated.
REQ-012 meas_ch  output  clog2(NCH) (min 1)  channel of current result.
REQ-013 meas_cnt  output  W  echo high time in clk cycles.
REQ-014 meas_timeout  output  1  qualifies meas_valid: result is a timeout, meas_cnt all ones.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Each echo bit SHALL pass a 2-flop synchronizer; only the selected channel's synchronized bit (echo_s) and its 1-cycle delayed copy (echo_d) are used; rise = echo_s & ~echo_d, fall = ~echo_s & echo_d.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-018 IDLE: all outputs inactive; enable=1 -> TRIG next cycle with current channel ch.
REQ-019 TRIG: trigger[ch]=1 for exactly TRIG_CYC consecutive cycles, all other trigger bits 0; then -> WAIT_RISE; echo edges during TRIG ignored.
REQ-020 WAIT_RISE: wait counter increments per cycle from 0; rise -> MEASURE with pulse count=1; wait counter reaching TIMEOUT_CYC with no rise -> timeout result, -> HOLDOFF.
REQ-021 MEASURE: pulse count increments by 1 each cycle echo_s stays 1; fall -> meas_cnt=count, meas_timeout=0, meas_valid=1, -> HOLDOFF; echo high for N synchronized cycles yields meas_cnt=N.
REQ-022 MEASURE: count reaching TIMEOUT_CYC before fall -> timeout result, -> HOLDOFF.
REQ-023 Timeout result: meas_cnt=2^W-1, meas_timeout=1, meas_valid=1, meas_ch=ch, single cycle.
REQ-024 meas_cnt, meas_ch, meas_timeout SHALL hold their last value until the next meas_valid; meas_valid is high for exactly one cycle per measurement.
REQ-025 HOLDOFF: HOLDOFF_CYC cycles; ch advances to (ch+1) mod NCH on exit (wrap NCH-1 -> 0); then -> TRIG if enable=1, else IDLE.
REQ-026 enable deasserted in TRIG, WAIT_RISE or MEASURE SHALL NOT abort the cycle; the result is still reported.
REQ-027 Exactly one measurement result per trigger; a second rise in MEASURE or HOLDOFF is ignored.
REQ-028 Counters SHALL never wrap; arithmetic unsigned W bits.
REQ-029 NCH=1: ch stays 0, meas_ch=0.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, trigger=0, meas_valid=0, meas_cnt=0, meas_ch=0, meas_timeout=0, busy=0, ch=0, all counters and synchronizer flops 0.
REQ-031 Reset mid-TRIG SHALL drop trigger in the same instant (asynchronously); after release the block starts from channel 0 with no partial result reported.

Verification
REQ-032 NCH=2, TRIG_CYC=10, enable=1 after reset -> trigger[0] high exactly 10 cycles, trigger[1]=0, busy=1.
REQ-033 echo[0] high 500 cycles after trigger ends -> one meas_valid with meas_ch=0, meas_cnt=500, meas_timeout=0.
REQ-034 No echo, TIMEOUT_CYC=1000 -> meas_valid 1000 cycles after WAIT_RISE entry, meas_cnt=16'hFFFF, meas_timeout=1.
REQ-035 NCH=3, continuous enable -> trigger order 0,1,2,0; trigger start spacing equals TRIG_CYC+wait+measure+HOLDOFF_CYC+overhead, constant for fixed echo.
REQ-036 enable dropped during MEASURE -> result still reported, then IDLE, busy=0, no further trigger.
REQ-037 rst_n pulsed low mid-MEASURE -> all outputs 0 at once, no meas_valid, next trigger on channel 0.

Source files
------------

// File: rtl/ultra_ranger.sv
// ultra_ranger: round-robin ultrasonic ranging controller for NCH sensors.
// Latency: trigger is registered; each result strobes 3 cycles after the raw echo falls
//   (2-flop synchronizer plus edge detect) or on the cycle the timeout limit is hit.
// Backpressure: none. meas_valid is a one-cycle strobe and the result fields hold until the next one.
// Ports:
//   clk, rst_n      single clock, asynchronous active-low reset
//   enable          run ranging cycles while high; low finishes the cycle in progress, then idles
//   echo[NCH]       raw asynchronous echo inputs, bit i from sensor i
//   trigger[NCH]    registered one-hot trigger pulses, bit i to sensor i
//   meas_valid      one-cycle strobe: meas_ch / meas_cnt / meas_timeout were updated
//   meas_ch         channel of the result
//   meas_cnt        echo high time in clk cycles (all ones on timeout)
//   meas_timeout    result is a timeout
//   busy            controller is anywhere other than IDLE
module ultra_ranger #(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int TRIG_CYC    = 11,
  parameter int TIMEOUT_CYC = 60000,
  parameter int HOLDOFF_CYC = 1000,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [NCH-1:0] echo,
  output logic [NCH-1:0] trigger,
  output logic           meas_valid,
  output logic [CHW-1:0] meas_ch,
  output logic [W-1:0]   meas_cnt,
  output logic           meas_timeout,
  output logic           busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  // One shared W-bit counter times every phase; TRIG_CYC and HOLDOFF_CYC
  // are expected to fit in W bits just like TIMEOUT_CYC.
  localparam logic [W-1:0]   TRIG_LAST = W'(TRIG_CYC - 1);
  localparam logic [W-1:0]   HOLD_LAST = W'(HOLDOFF_CYC - 1);
  localparam logic [W-1:0]   TO_LIMIT  = W'(TIMEOUT_CYC);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NCH - 1);
  localparam logic [NCH-1:0] ONE_HOT0  = NCH'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic           echo_dly_q;
  logic [NCH-1:0] trig_q, trig_d;
  logic           mv_q, mv_d;
  logic [CHW-1:0] mch_q, mch_d;
  logic [W-1:0]   mcnt_q, mcnt_d;
  logic           mto_q, mto_d;

  logic           echo_s;
  logic           rise;
  logic           fall;
  logic [W-1:0]   cnt_inc;
  logic [CHW-1:0] ch_next;
  logic           res_hit;
  logic           res_to;

  // Only the serviced channel is edge-detected. echo_dly_q may briefly hold
  // the previous channel's level after a channel switch, but that happens
  // during TRIG where edges are ignored anyway.
  assign echo_s  = sync2_q[ch_q];
  assign rise    = echo_s & ~echo_dly_q;
  assign fall    = ~echo_s & echo_dly_q;

  // Timeout limit is below 2^W-1, so the increment never wraps.
  assign cnt_inc = cnt_q + W'(1);
  assign ch_next = (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    res_hit = 1'b0;
    res_to  = 1'b0;
    mv_d    = 1'b0;
    mch_d   = mch_q;
    mcnt_d  = mcnt_q;
    mto_d   = mto_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end

      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_RISE: begin
        if (rise) begin
          // The rise cycle itself is the first high cycle of the echo.
          state_d = MEASURE;
          cnt_d   = W'(1);
        end else if (cnt_inc >= TO_LIMIT) begin
          res_hit = 1'b1;
          res_to  = 1'b1;
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      MEASURE: begin
        // In MEASURE the delayed echo is always high, so "not fall" means
        // the echo is still high this cycle.
        if (fall) begin
          res_hit = 1'b1;
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else if (cnt_inc >= TO_LIMIT) begin
          res_hit = 1'b1;
          res_to  = 1'b1;
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      HOLDOFF: begin
        // Echo activity is ignored here: one result per trigger.
        if (cnt_q == HOLD_LAST) begin
          ch_d    = ch_next;
          cnt_d   = '0;
          state_d = enable ? TRIG : IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (res_hit) begin
      mv_d   = 1'b1;
      mch_d  = ch_q;
      mcnt_d = res_to ? '1 : cnt_q;
      mto_d  = res_to;
    end

    // Trigger register tracks the TRIG state exactly, one bit per channel.
    trig_d = (state_d == TRIG) ? (ONE_HOT0 << ch_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      echo_dly_q <= 1'b0;
      trig_q     <= '0;
      mv_q       <= 1'b0;
      mch_q      <= '0;
      mcnt_q     <= '0;
      mto_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      sync1_q    <= echo;
      sync2_q    <= sync1_q;
      echo_dly_q <= echo_s;
      trig_q     <= trig_d;
      mv_q       <= mv_d;
      mch_q      <= mch_d;
      mcnt_q     <= mcnt_d;
      mto_q      <= mto_d;
    end
  end

  assign trigger      = trig_q;
  assign meas_valid   = mv_q;
  assign meas_ch      = mch_q;
  assign meas_cnt     = mcnt_q;
  assign meas_timeout = mto_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ultra_ranger.sv
// tb_ultra_ranger: randomized bench for ultra_ranger with a transaction-level reference.
// Latency: results are matched by order against an expected (channel, length) plan.
// Backpressure: none; the bench plays the sensors and answers each trigger with an echo.
module tb_ultra_ranger;

  localparam int NCH = 3;
  localparam int W   = 16;
  localparam int TC  = 10;
  localparam int TO  = 1000;
  localparam int HO  = 50;
  localparam int CHW = 2;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b1;
  logic           enable = 1'b0;
  logic [NCH-1:0] echo   = '0;
  logic [NCH-1:0] trigger;
  logic           meas_valid;
  logic [CHW-1:0] meas_ch;
  logic [W-1:0]   meas_cnt;
  logic           meas_timeout;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dbl   = 0;
  int ch_m  = 0;   // channel the model expects to be serviced next
  bit prev_v = 1'b0;

  typedef struct {
    int ch;
    int cnt;
    bit to;
    int cyc;
  } res_t;
  res_t res_q[$];

  ultra_ranger #(
    .NCH(NCH), .W(W), .TRIG_CYC(TC), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(HO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
    .trigger(trigger), .meas_valid(meas_valid), .meas_ch(meas_ch),
    .meas_cnt(meas_cnt), .meas_timeout(meas_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) res_q.push_back('{int'(meas_ch), int'(meas_cnt), meas_timeout, cyc});
    if (meas_valid && prev_v) dbl <= dbl + 1;
    prev_v <= meas_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Expected result for an echo of len synchronized cycles (0 = no echo).
  function automatic void expect_res(input int len, output int cnt, output bit to);
    if (len == 0 || len >= TO) begin
      cnt = (1 << W) - 1;
      to  = 1'b1;
    end else begin
      cnt = len;
      to  = 1'b0;
    end
  endfunction

  task automatic wait_trig(output int c, output int ts, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    c  = -1;
    ts = 0;
    while (trigger == '0 && n < 2 * (TC + TO + HO) + 200) begin
      @(negedge clk);
      n++;
    end
    if (trigger != '0) begin
      ok = $onehot(trigger);
      ts = cyc;
      for (int i = 0; i < NCH; i++) if (trigger[i]) c = i;
    end
  endtask

  task automatic wait_result(output res_t r, output bit got);
    int n;
    n = 0;
    while (res_q.size() == 0 && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    got = (res_q.size() != 0);
    if (got) r = res_q.pop_front();
    else r = '{-1, -1, 1'b0, 0};
  endtask

  // One full ranging cycle: trigger shape, echo of len cycles after dly, result.
  task automatic run_meas(input int len, input int dly, input bit glitch, output int ts);
    int c, tl, wr, ecnt;
    bit ok, got, to_e, bsy;
    res_t r;
    wait_trig(c, ts, ok);
    bsy = busy;
    total++;
    if (c != ch_m || !ok || bsy !== 1'b1) begin
      bad++;
      $display("FAIL trig_start: got ch=%0d onehot=%0d busy=%0b, want ch=%0d onehot=1 busy=1", c, ok, bsy, ch_m);
    end
    if (c < 0) return;
    tl = 0;
    while (trigger == (NCH'(1) << c) && tl < TC + 20) begin
      tl++;
      @(negedge clk);
    end
    total++;
    if (tl != TC || trigger !== '0) begin
      bad++;
      $display("FAIL trig_len: got %0d cycles then %b, want %0d cycles then 0", tl, trigger, TC);
    end
    wr = cyc;
    repeat (dly) @(negedge clk);
    if (len > 0) begin
      echo[c] = 1'b1;
      repeat (len) @(negedge clk);
      echo[c] = 1'b0;
    end
    if (glitch) begin
      repeat (10) @(negedge clk);
      echo[c] = 1'b1;
      repeat (3) @(negedge clk);
      echo[c] = 1'b0;
    end
    wait_result(r, got);
    expect_res(len, ecnt, to_e);
    total++;
    if (!got || r.ch != ch_m || r.cnt != ecnt || r.to != to_e) begin
      bad++;
      $display("FAIL meas len=%0d: got valid=%0b ch=%0d cnt=%0d to=%0b, want ch=%0d cnt=%0d to=%0b",
               len, got, r.ch, r.cnt, r.to, ch_m, ecnt, to_e);
    end
    if (got && len == 0) begin
      total++;
      if (r.cyc - wr != TO) begin
        bad++;
        $display("FAIL wait_timeout_time: got %0d cycles, want %0d", r.cyc - wr, TO);
      end
    end
    if (glitch) begin
      repeat (10) @(negedge clk);
      total++;
      if (res_q.size() != 0) begin
        bad++;
        $display("FAIL extra_result: got %0d extra results, want 0", res_q.size());
        res_q.delete();
      end
    end
    ch_m = (ch_m + 1) % NCH;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy} !== '0) begin
      bad++;
      $display("FAIL reset_state: got trig=%b v=%b ch=%0d cnt=%0d to=%b busy=%b, want all 0",
               trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || trigger !== '0 || meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_disabled: got busy=%b trig=%b v=%b, want 0 0 0", busy, trigger, meas_valid);
    end
    ch_m = 0;
  endtask

  task automatic test_first_echo();
    int ts;
    enable = 1'b1;
    run_meas(500, 7, 1'b0, ts);
    repeat (20) @(negedge clk);
    total++;
    if (meas_cnt !== 16'd500 || meas_ch !== 2'd0 || meas_timeout !== 1'b0 || meas_valid !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: got cnt=%0d ch=%0d to=%b v=%b, want 500 0 0 0",
               meas_cnt, meas_ch, meas_timeout, meas_valid);
    end
  endtask

  task automatic test_wait_timeout();
    int t1, t2;
    run_meas(0, 0, 1'b0, t1);
    run_meas(1, 0, 1'b1, t2);
    total++;
    if (t2 - t1 != TC + TO + HO) begin
      bad++;
      $display("FAIL timeout_spacing: got %0d cycles, want %0d", t2 - t1, TC + TO + HO);
    end
  endtask

  task automatic test_measure_limit();
    int ts;
    run_meas(TO - 1, 2, 1'b1, ts);
    run_meas(TO + 5, 3, 1'b1, ts);
  endtask

  task automatic test_round_robin();
    int ts[4];
    for (int i = 0; i < 4; i++) run_meas(40, 5, 1'b0, ts[i]);
    for (int i = 2; i < 4; i++) begin
      total++;
      if (ts[i] - ts[i-1] != ts[1] - ts[0]) begin
        bad++;
        $display("FAIL rr_spacing[%0d]: got %0d, want %0d", i, ts[i] - ts[i-1], ts[1] - ts[0]);
      end
    end
  endtask

  task automatic test_random();
    int ts, len, dly;
    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(1, 400));
      dly = int'($urandom_range(0, 150));
      run_meas(len, dly, 1'b1, ts);
    end
  endtask

  task automatic test_enable_drop();
    int c, ts, ntrig;
    bit ok, got;
    res_t r;
    wait_trig(c, ts, ok);
    total++;
    if (c != ch_m || !ok) begin
      bad++;
      $display("FAIL drop_trig_ch: got %0d, want %0d", c, ch_m);
    end
    if (c < 0) return;
    repeat (TC + 3) @(negedge clk);
    echo[c] = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (15) @(negedge clk);
    echo[c] = 1'b0;
    wait_result(r, got);
    total++;
    if (!got || r.ch != ch_m || r.cnt != 25 || r.to != 1'b0) begin
      bad++;
      $display("FAIL drop_result: got valid=%0b ch=%0d cnt=%0d to=%0b, want ch=%0d cnt=25 to=0",
               got, r.ch, r.cnt, r.to, ch_m);
    end
    ch_m = (ch_m + 1) % NCH;
    repeat (HO + 5) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got busy=%b, want 0", busy);
    end
    ntrig = 0;
    repeat (300) begin
      @(negedge clk);
      if (trigger != '0) ntrig++;
    end
    total++;
    if (ntrig != 0) begin
      bad++;
      $display("FAIL drop_no_trigger: got %0d trigger cycles, want 0", ntrig);
    end
  endtask

  task automatic test_reset_mid();
    int c, ts;
    bit ok;
    enable = 1'b1;
    wait_trig(c, ts, ok);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_trig: got trig=%b v=%b ch=%0d cnt=%0d to=%b busy=%b, want all 0",
               trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ch_m = 0;
    wait_trig(c, ts, ok);
    total++;
    if (c != 0 || !ok) begin
      bad++;
      $display("FAIL reset_restart_ch: got %0d, want 0", c);
    end
    if (c < 0) return;
    repeat (TC + 3) @(negedge clk);
    echo[0] = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_meas: got trig=%b v=%b ch=%0d cnt=%0d to=%b busy=%b, want all 0",
               trigger, meas_valid, meas_ch, meas_cnt, meas_timeout, busy);
    end
    echo = '0;
    repeat (20) @(negedge clk);
    total++;
    if (res_q.size() != 0) begin
      bad++;
      $display("FAIL reset_partial_result: got %0d results, want 0", res_q.size());
      res_q.delete();
    end
    rst_n = 1'b1;
    ch_m = 0;
    run_meas(77, 4, 1'b1, ts);
  endtask

  initial begin
    test_reset();
    test_first_echo();
    test_wait_timeout();
    test_measure_limit();
    test_round_robin();
    test_random();
    test_enable_drop();
    test_reset_mid();
    total++;
    if (dbl != 0) begin
      bad++;
      $display("FAIL valid_width: got %0d multi-cycle strobes, want 0", dbl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
